apb_req_arbiter: RTL

//  Shares the single APB master internal port (transfer/ready/addr/wdata/write/rdata) between NUM_REQ requesters.

---
 rtl/apb_req_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters.
// Out-of-window or misaligned addresses are rejected locally, without any bus transfer.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] MAP_SIZE  = 32'h0000_4000
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_write,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [31:0]            req_rdata,
  output logic                   busy,
  output logic                   m_transfer,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  output logic                   m_write,
  input  logic                   m_ready,
  input  logic [31:0]            m_rdata
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + {1'b0, MAP_SIZE};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, grant, winner, grant_inc;
  logic               any_req;
  logic [31:0]        sel_addr, sel_wdata;
  logic               sel_write;
  logic               addr_ok;
  logic [31:0]        rdata_q;

  // First pending requester scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_req   = 1'b0;
    winner    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!any_req && req_valid[IDX_W'(idx)]) begin
        any_req   = 1'b1;
        winner    = IDX_W'(idx);
        sel_addr  = req_addr[idx*32 +: 32];
        sel_wdata = req_wdata[idx*32 +: 32];
        sel_write = req_write[IDX_W'(idx)];
      end
    end
  end

  assign addr_ok = (sel_addr >= BASE_ADDR) && ({1'b0, sel_addr} < WIN_END) &&
                   (sel_addr[1:0] == 2'b00);

  assign grant_inc = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (any_req) state_nx = addr_ok ? S_ISSUE : S_ERR;
      S_ISSUE:  state_nx = S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (m_ready) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      m_transfer <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_write    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nx;
      m_transfer <= (state_nx == S_ISSUE);
      if (state == S_IDLE && any_req) begin
        grant   <= winner;
        m_addr  <= sel_addr;
        m_wdata <= sel_wdata;
        m_write <= sel_write;
      end
      if (state == S_ACCESS && m_ready) rdata_q <= m_write ? '0 : m_rdata;
      if (state == S_DONE || state == S_ERR) rr_ptr <= grant_inc;
    end
  end

  always_comb begin
    req_done  = '0;
    req_err   = '0;
    req_rdata = '0;
    busy      = (state != S_IDLE);
    if (state == S_DONE) begin
      req_done[grant] = 1'b1;
      req_rdata       = rdata_q;
    end
    if (state == S_ERR) begin
      req_done[grant] = 1'b1;
      req_err[grant]  = 1'b1;
    end
  end

endmodule
